// File: rtl/sram_ring_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ring_buffer_pkg
// Description : Shared SRAM geometry constants and controller state encoding
//               for the SRAM ring-buffer FIFO and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ring_buffer_pkg;

    // External SRAM geometry: 1M x 16
    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    // Controller states; SRAM strobes are decoded from the next state
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_SETUP   = 3'd1,
        ST_WR_STROBE  = 3'd2,
        ST_WR_HOLD    = 3'd3,
        ST_RD_SETUP   = 3'd4,
        ST_RD_CAPTURE = 3'd5
    } state_t;

    // Direction of the most recently granted SRAM access
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/sram_if_phy.sv
`default_nettype none
// ============================================================================
// Module      : sram_if_phy
// Description : SRAM pin layer. Registers address, write data and active-low
//               strobes from the controller's next state, owns the SRAM_IO
//               tristate and exposes the raw read data.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_if_phy
    import sram_ring_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  state_t                i_next_state,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [SRAM_DW-1:0]    i_wr_data,
    output logic [SRAM_DW-1:0]    o_rd_data,
    output logic [SRAM_AW-1:0]    o_sram_a,
    inout  wire  [SRAM_DW-1:0]    io_sram_data,
    output logic                  o_sram_bhe_b,
    output logic                  o_sram_ble_b,
    output logic                  o_sram_ce1_b,
    output logic                  o_sram_oe_b,
    output logic                  o_sram_we_b
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [SRAM_DW-1:0]    r_wdata;
    logic                  r_drive;
    logic                  r_we_b;
    logic                  r_oe_b;
    logic                  r_ce_b;

    // Pin registers: address/data captured on entry to a setup state, strobes
    // follow the next state so the pins change only on clock edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_drive <= 1'b0;
            r_we_b  <= 1'b1;
            r_oe_b  <= 1'b1;
            r_ce_b  <= 1'b1;
        end else begin
            r_ce_b  <= 1'b0;
            r_we_b  <= (i_next_state != ST_WR_STROBE);
            r_oe_b  <= !((i_next_state == ST_RD_SETUP) ||
                         (i_next_state == ST_RD_CAPTURE));
            r_drive <= (i_next_state == ST_WR_SETUP)  ||
                       (i_next_state == ST_WR_STROBE) ||
                       (i_next_state == ST_WR_HOLD);
            if (i_next_state == ST_WR_SETUP) begin
                r_addr  <= i_wr_addr;
                r_wdata <= i_wr_data;
            end
            if (i_next_state == ST_RD_SETUP) begin
                r_addr <= i_rd_addr;
            end
        end
    end

    // Unused upper address lines are tied low for small rings
    generate
        if (ADDR_WIDTH < SRAM_AW) begin : g_addr_pad
            assign o_sram_a = {{(SRAM_AW-ADDR_WIDTH){1'b0}}, r_addr};
        end else begin : g_addr_full
            assign o_sram_a = r_addr;
        end
    endgenerate

    // Data bus is driven only through the three write states
    assign io_sram_data = r_drive ? r_wdata : {SRAM_DW{1'bz}};
    assign o_rd_data    = io_sram_data;

    assign o_sram_bhe_b = r_ce_b;
    assign o_sram_ble_b = r_ce_b;
    assign o_sram_ce1_b = r_ce_b;
    assign o_sram_oe_b  = r_oe_b;
    assign o_sram_we_b  = r_we_b;

endmodule
`default_nettype wire

// File: rtl/sram_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sram_ring_buffer
// Description : Valid/ready streaming FIFO backed by an external asynchronous
//               1M x 16 SRAM used as a ring buffer. Alternates write/read
//               grants when both are pending; one word per 4 cycles per side.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ring_buffer
    import sram_ring_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    input  logic                  CLEAR,
    input  logic [SRAM_DW-1:0]    IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [SRAM_DW-1:0]    OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [ADDR_WIDTH:0]   FILL_LEVEL,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [SRAM_AW-1:0]    SRAM_A,
    inout  wire  [SRAM_DW-1:0]    SRAM_IO,
    output logic                  SRAM_BHE_B,
    output logic                  SRAM_BLE_B,
    output logic                  SRAM_CE1_B,
    output logic                  SRAM_OE_B,
    output logic                  SRAM_WE_B
);

    localparam logic [ADDR_WIDTH:0]   C_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next_state;
    op_t                   r_last_op;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [SRAM_DW-1:0]    r_out_data;
    logic                  r_out_valid;
    logic [SRAM_DW-1:0]    w_rd_data;

    logic w_rst;
    logic w_idle;
    logic w_full;
    logic w_empty;
    logic w_read_req;
    logic w_write_req;
    logic w_grant_wr;
    logic w_grant_rd;

    assign w_rst       = BUS_RST || CLEAR;
    assign w_idle      = (r_state == ST_IDLE);
    assign w_full      = (r_count == C_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_read_req  = !w_empty && !r_out_valid;
    assign w_write_req = IN_VALID && !w_full;

    // When both sides want the bus, the side that did not go last wins
    assign w_grant_wr = w_idle && !w_rst && w_write_req &&
                        (!w_read_req || (r_last_op == OP_READ));
    assign w_grant_rd = w_idle && !w_rst && w_read_req &&
                        (!w_write_req || (r_last_op == OP_WRITE));

    // Ready is withheld when a pending read has priority, independent of IN_VALID
    assign IN_READY = w_idle && !w_full && !w_rst &&
                      !(w_read_req && (r_last_op == OP_WRITE));

    // State register
    always_ff @(posedge BUS_CLK) begin
        if (w_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: fixed-length write and read sequences from IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_wr) begin
                    w_next_state = ST_WR_SETUP;
                end else if (w_grant_rd) begin
                    w_next_state = ST_RD_SETUP;
                end
            end
            ST_WR_SETUP:   w_next_state = ST_WR_STROBE;
            ST_WR_STROBE:  w_next_state = ST_WR_HOLD;
            ST_WR_HOLD:    w_next_state = ST_IDLE;
            ST_RD_SETUP:   w_next_state = ST_RD_CAPTURE;
            ST_RD_CAPTURE: w_next_state = ST_IDLE;
            default:       w_next_state = ST_IDLE;
        endcase
        if (w_rst) begin
            w_next_state = ST_IDLE;
        end
    end

    // Occupancy, pointers, arbitration history and the output word register
    always_ff @(posedge BUS_CLK) begin
        if (w_rst) begin
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last_op   <= OP_READ;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_grant_wr) begin
                r_count   <= r_count + C_CNT_ONE;
                r_last_op <= OP_WRITE;
            end else if (w_grant_rd) begin
                r_count   <= r_count - C_CNT_ONE;
                r_last_op <= OP_READ;
            end

            if (r_state == ST_WR_HOLD) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end

            if (r_state == ST_RD_CAPTURE) begin
                r_out_data  <= w_rd_data;
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + C_PTR_ONE;
            end else if (r_out_valid && OUT_READY) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign OUT_DATA   = r_out_data;
    assign OUT_VALID  = r_out_valid;
    assign FILL_LEVEL = r_count;
    assign FULL       = w_full;
    assign EMPTY      = w_empty;

    sram_if_phy #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_phy (
        .clk          (BUS_CLK),
        .rst          (w_rst),
        .i_next_state (w_next_state),
        .i_wr_addr    (r_wr_ptr),
        .i_rd_addr    (r_rd_ptr),
        .i_wr_data    (IN_DATA),
        .o_rd_data    (w_rd_data),
        .o_sram_a     (SRAM_A),
        .io_sram_data (SRAM_IO),
        .o_sram_bhe_b (SRAM_BHE_B),
        .o_sram_ble_b (SRAM_BLE_B),
        .o_sram_ce1_b (SRAM_CE1_B),
        .o_sram_oe_b  (SRAM_OE_B),
        .o_sram_we_b  (SRAM_WE_B)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ring_buffer
// Description : Self-checking bench for sram_ring_buffer (16-word ring) with a
//               behavioural asynchronous SRAM and a queue-based FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ring_buffer;
    import sram_ring_buffer_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b1;
    logic        clr       = 1'b0;
    logic [15:0] in_data   = '0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;

    wire         in_ready;
    wire  [15:0] out_data;
    wire         out_valid;
    wire  [AW:0] fill;
    wire         full;
    wire         empty;
    wire  [19:0] sram_a;
    wire  [15:0] sram_io;
    wire         bhe_b, ble_b, ce_b, oe_b, we_b;

    sram_ring_buffer #(.ADDR_WIDTH(AW)) dut (
        .BUS_CLK    (clk),
        .BUS_RST    (rst),
        .CLEAR      (clr),
        .IN_DATA    (in_data),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .OUT_DATA   (out_data),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .FILL_LEVEL (fill),
        .FULL       (full),
        .EMPTY      (empty),
        .SRAM_A     (sram_a),
        .SRAM_IO    (sram_io),
        .SRAM_BHE_B (bhe_b),
        .SRAM_BLE_B (ble_b),
        .SRAM_CE1_B (ce_b),
        .SRAM_OE_B  (oe_b),
        .SRAM_WE_B  (we_b)
    );

    // Behavioural asynchronous SRAM
    logic [15:0] mem [0:DEPTH-1];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0;
    assign sram_io = (!oe_b && !ce_b) ? mem[sram_a[3:0]] : 16'hzzzz;
    always @(negedge we_b) mem[sram_a[3:0]] = sram_io;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: words accepted and not yet consumed (sq) and words
    // accepted but not yet strobed into the SRAM (wq)
    logic [15:0] sq[$];
    logic [15:0] wq[$];
    int          wr_idx   = 0;
    int          we_low   = 0;
    logic        prev_we  = 1'b1;
    logic        prev_oe  = 1'b1;
    logic        alt_en   = 1'b0;
    int          alt_last = 0;
    int          alt_events = 0;

    always @(negedge clk) begin
        if (rst || clr) begin
            sq.delete();
            wq.delete();
            wr_idx  = 0;
            we_low  = 0;
            prev_we = 1'b1;
            prev_oe = 1'b1;
        end else begin
            int diff;
            int op;
            diff = sq.size() - int'(out_valid) - int'(fill);
            chk("fill_level_window", (diff == 0 || diff == 1), 1);

            if (prev_we && !we_b) begin
                chk("write_addr", sram_a, {16'h0, 4'(wr_idx)});
                if (wq.size() == 0) chk("write_unexpected", 1, 0);
                else                chk("write_data", sram_io, wq.pop_front());
                wr_idx++;
            end
            if (!we_b) we_low++;
            else begin
                if (we_low != 0) chk("we_low_cycles", we_low, 1);
                we_low = 0;
            end
            if (!oe_b) begin
                chk("read_bus_contention", sram_io, mem[sram_a[3:0]]);
                chk("we_during_read", we_b, 1);
            end

            op = 0;
            if (prev_we && !we_b) op = 1;
            if (prev_oe && !oe_b) op = 2;
            if (!alt_en) alt_last = 0;
            else if (op != 0) begin
                if (alt_last != 0) chk("grant_alternation", op, 3 - alt_last);
                alt_last = op;
                alt_events++;
            end

            if (in_valid && in_ready) begin
                sq.push_back(in_data);
                wq.push_back(in_data);
            end
            if (out_valid && out_ready) begin
                if (sq.size() == 0) chk("pop_unexpected", 1, 0);
                else                chk("out_data_order", out_data, sq.pop_front());
            end
            prev_we = we_b;
            prev_oe = oe_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d);
        logic acc;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_out_valid();
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic drain();
        logic done;
        done     = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (sq.size() == 0 && !out_valid && fill == 0) done = 1'b1;
        end
        out_ready = 1'b0;
        repeat (6) tick();
        chk("drain_complete", done, 1);
        chk("drain_empty", empty, 1);
    endtask

    initial begin
        int   n_acc;
        logic acc;
        logic [15:0] w;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_we_b", we_b, 1);
        chk("rst_oe_b", oe_b, 1);
        chk("rst_ce_b", {ce_b, bhe_b, ble_b}, 3'b111);
        chk("rst_addr", sram_a, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_fill", fill, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ce_b", {ce_b, bhe_b, ble_b}, 3'b000);
        chk("post_rst_in_ready", in_ready, 1);

        // Single word: exact write and read timing
        in_data  = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("wr_setup_we_b", we_b, 1);
        chk("wr_setup_addr", sram_a, 0);
        chk("wr_setup_io", sram_io, 16'h1234);
        chk("wr_setup_fill", fill, 1);
        tick();
        chk("wr_strobe_we_b", we_b, 0);
        tick();
        chk("wr_hold_we_b", we_b, 1);
        chk("wr_hold_io", sram_io, 16'h1234);
        repeat (3) tick();
        chk("rd_capture_oe_b", oe_b, 0);
        chk("rd_capture_valid", out_valid, 0);
        chk("rd_fill", fill, 0);
        tick();
        chk("rd_done_valid", out_valid, 1);
        chk("rd_done_oe_b", oe_b, 1);
        chk("rd_done_data", out_data, 16'h1234);
        chk("rd_done_empty", empty, 1);
        repeat (4) tick();
        chk("out_valid_held", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_cleared", out_valid, 0);

        // Fill to FULL with the output register stalled
        n_acc = 0;
        w     = 16'h0000;
        for (int i = 0; i < 200 && !full; i++) begin
            in_valid = 1'b1;
            in_data  = w;
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                n_acc++;
                w++;
            end
        end
        chk("full_flag", full, 1);
        chk("full_fill", fill, 16);
        chk("full_accepted", n_acc, 17);
        in_data = w;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        push_word(w);
        drain();

        // Randomized traffic through the ring (address wraps several times)
        n_acc = 0;
        w     = 16'h4000;
        for (int i = 0; i < 3000 && n_acc < 48; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = w;
            out_ready = 1'($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                n_acc++;
                w = 16'($urandom);
            end
        end
        chk("random_accepted", n_acc, 48);
        drain();

        // Continuous traffic on both sides: grants must alternate
        alt_en    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) in_data = 16'($urandom);
        end
        alt_en   = 1'b0;
        in_valid = 1'b0;
        chk("alternation_events", alt_events >= 20, 1);
        drain();

        // Reset in the middle of a write strobe
        push_word(16'hAAAA);
        for (int i = 0; i < 6 && we_b; i++) tick();
        chk("strobe_reached", we_b, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_we_b", we_b, 1);
        chk("mid_rst_oe_b", oe_b, 1);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        rst = 1'b0;
        tick();
        push_word(16'h5555);
        for (int i = 0; i < 6 && we_b; i++) tick();
        chk("after_rst_addr", sram_a, 0);
        wait_out_valid();
        chk("after_rst_data", out_data, 16'h5555);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (4) tick();

        // CLEAR with words stored and the output register occupied
        for (int i = 0; i < 6; i++) push_word(16'h0100 + 16'(i));
        repeat (12) tick();
        chk("pre_clear_fill", fill, 5);
        chk("pre_clear_valid", out_valid, 1);
        chk("pre_clear_data", out_data, 16'h0100);
        clr = 1'b1;
        tick();
        chk("clear_fill", fill, 0);
        chk("clear_out_valid", out_valid, 0);
        chk("clear_empty", empty, 1);
        chk("clear_in_ready", in_ready, 0);
        clr = 1'b0;
        tick();
        push_word(16'hBEEF);
        wait_out_valid();
        chk("after_clear_data", out_data, 16'hBEEF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (4) tick();
        chk("final_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
